// File: rtl/uart_rx_sipo_if.sv
// Receiver-side bus: serial line in, framed word and status strobes out.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_sipo_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  serial_in;
  logic [DATA_WIDTH-1:0] parallel_out;
  logic                  data_valid;
  logic                  framing_err;
  logic                  busy;
`ifdef UART_RX_PARITY_EN
  logic                  parity_err;
`endif

  modport master (
    input  serial_in,
    output parallel_out,
    output data_valid,
    output framing_err,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output busy
  );

  modport slave (
    output serial_in,
    input  parallel_out,
    input  data_valid,
    input  framing_err,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  busy
  );
endinterface

// File: rtl/uart_rx_sipo.sv
// Oversampled UART receiver (serial -> parallel), even parity when UART_RX_PARITY_EN is defined.
// Pulse OVERSAMPLE/2+(DATA_WIDTH+1)*OVERSAMPLE (+OVERSAMPLE parity) cycles after start seen; no backpressure.
module uart_rx_sipo #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic            rx_clk,
  input  logic            rst_n,
  uart_rx_sipo_if.master  rx
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [TW-1:0]         tick;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  valid_q;
  logic                  ferr_q;
  logic                  busy_q;
  logic [1:0]            rst_pipe;
  logic                  rst_core_n;
  logic [1:0]            sync_q;
  logic                  rxs;
  logic                  par_bad;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit;
  logic                  perr_q;
`endif

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end
  assign rst_core_n = rst_pipe[1];

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx.serial_in};
    end
  end
  assign rxs = sync_q[1];

`ifdef UART_RX_PARITY_EN
  assign par_bad = (^shreg) ^ par_bit;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge rx_clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          tick <= '0;
          if (!rxs) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (tick == TICK_MID) begin
            tick    <= '0;
            bit_cnt <= '0;
            // Line back high by mid start bit: treat as noise.
            if (rxs) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (tick == TICK_END) begin
            tick    <= '0;
            shreg   <= {rxs, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick == TICK_END) begin
            tick    <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
`endif
        STOP: begin
          // Leave at mid stop bit so a following start edge is not missed.
          if (tick == TICK_END) begin
            tick   <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
            if (!rxs) begin
              ferr_q <= 1'b1;
            end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
              perr_q <= 1'b1;
`endif
            end else begin
              word_q  <= shreg;
              valid_q <= 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tick   <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.parallel_out = word_q;
  assign rx.data_valid   = valid_q;
  assign rx.framing_err  = ferr_q;
  assign rx.busy         = busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx.parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Scoreboard bench for uart_rx_sipo: frames are driven bit-serially, expected pulses queued with their cycle.
module tb_uart_rx_sipo;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = OS / 2 + 10 * OS;
`else
  localparam int LAT = OS / 2 + 9 * OS;
`endif
  // Line change is seen by the FSM 3 edges later (two sync flops, then state register).
  localparam int SYNC_DLY = 3;

  typedef struct {
    logic [2:0] kind;   // {parity, framing, valid}
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic rx_clk = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;
  logic [7:0] last_good = 8'h00;
  exp_t q[$];

  uart_rx_sipo_if #(.DATA_WIDTH(8)) rx_bus ();

  uart_rx_sipo #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
    .rx_clk (rx_clk),
    .rst_n  (rst_n),
    .rx     (rx_bus)
  );

  always #5 rx_clk = ~rx_clk;
  always @(posedge rx_clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must match the head of the queue in kind, word and cycle.
  always @(negedge rx_clk) begin
    logic [2:0] obs;
    exp_t e;
`ifdef UART_RX_PARITY_EN
    obs = {rx_bus.parity_err, rx_bus.framing_err, rx_bus.data_valid};
`else
    obs = {1'b0, rx_bus.framing_err, rx_bus.data_valid};
`endif
    if (obs !== 3'b000) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: got strobes %b at cycle %0d, required none", obs, cyc);
      end else begin
        e = q.pop_front();
        checks += 3;
        if (obs !== e.kind)
          $display("FAIL pulse_kind: got %b, required %b", obs, e.kind);
        else passes++;
        if (rx_bus.parallel_out !== e.data)
          $display("FAIL parallel_out: got %h, required %h", rx_bus.parallel_out, e.data);
        else passes++;
        if (cyc !== e.cyc)
          $display("FAIL pulse_cycle: got %0d, required %0d", cyc, e.cyc);
        else passes++;
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge rx_clk);
      #1;
    end
  endtask

  // Drives one frame; par_flip inverts the even-parity bit when parity is built in.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    exp_t e;
    e.cyc = cyc + SYNC_DLY + LAT;
    if (!stop) begin
      e.kind = 3'b010; e.data = last_good;
`ifdef UART_RX_PARITY_EN
    end else if (par_flip) begin
      e.kind = 3'b100; e.data = last_good;
`endif
    end else begin
      e.kind = 3'b001; e.data = d; last_good = d;
    end
    q.push_back(e);
    rx_bus.serial_in = 1'b0;
    tick_n(OS);
    for (int i = 0; i < 8; i++) begin
      rx_bus.serial_in = d[i];
      tick_n(OS);
    end
`ifdef UART_RX_PARITY_EN
    rx_bus.serial_in = (^d) ^ par_flip;
    tick_n(OS);
`endif
    rx_bus.serial_in = stop;
    tick_n(OS);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_bus.serial_in = 1'b1;
    tick_n(4);
    checks += 4;
    if (rx_bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", rx_bus.busy); else passes++;
    if (rx_bus.data_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", rx_bus.data_valid); else passes++;
    if (rx_bus.framing_err !== 1'b0) $display("FAIL reset_ferr: got %b, required 0", rx_bus.framing_err); else passes++;
    if (rx_bus.parallel_out !== 8'h00) $display("FAIL reset_word: got %h, required 00", rx_bus.parallel_out); else passes++;
    rst_n = 1'b1;
    tick_n(20);
    checks++;
    if (rx_bus.busy !== 1'b0) $display("FAIL idle_busy: got %b, required 0", rx_bus.busy); else passes++;
  endtask

  task automatic test_single_frame();
    send_frame(8'hA5, 1'b1, 1'b0);
    tick_n(4);
    checks += 2;
    if (q.size() !== 0) $display("FAIL frame_a5_drain: got %0d pending, required 0", q.size()); else passes++;
    if (rx_bus.busy !== 1'b0) $display("FAIL frame_a5_busy: got %b, required 0", rx_bus.busy); else passes++;
    tick_n(10);
  endtask

  task automatic test_glitch();
    int c0;
    c0 = cyc;
    rx_bus.serial_in = 1'b0;
    tick_n(4);
    rx_bus.serial_in = 1'b1;
    while (cyc < c0 + SYNC_DLY + OS / 2 - 1) tick_n(1);
    checks++;
    if (rx_bus.busy !== 1'b1) $display("FAIL glitch_busy_start: got %b, required 1", rx_bus.busy); else passes++;
    tick_n(1);
    checks++;
    if (rx_bus.busy !== 1'b0) $display("FAIL glitch_busy_drop: got %b, required 0", rx_bus.busy); else passes++;
    tick_n(40);
    checks++;
    if (rx_bus.parallel_out !== last_good)
      $display("FAIL glitch_word: got %h, required %h", rx_bus.parallel_out, last_good);
    else passes++;
  endtask

  task automatic test_framing();
    send_frame(8'h5A, 1'b1, 1'b0);
    tick_n(10);
    send_frame(8'h3C, 1'b0, 1'b0);
    rx_bus.serial_in = 1'b1;
    tick_n(40);
    checks += 2;
    if (q.size() !== 0) $display("FAIL framing_drain: got %0d pending, required 0", q.size()); else passes++;
    if (rx_bus.parallel_out !== 8'h5A) $display("FAIL framing_word: got %h, required 5a", rx_bus.parallel_out); else passes++;
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    tick_n(10);
    checks++;
    if (q.size() !== 0) $display("FAIL b2b_drain: got %0d pending, required 0", q.size()); else passes++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h81;
    rx_bus.serial_in = 1'b0;
    tick_n(OS);
    for (int i = 0; i < 4; i++) begin
      rx_bus.serial_in = d[i];
      tick_n(OS);
    end
    rx_bus.serial_in = d[4];
    tick_n(OS / 2);
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (rx_bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b, required 0", rx_bus.busy); else passes++;
    if (rx_bus.parallel_out !== 8'h00) $display("FAIL midrst_word: got %h, required 00", rx_bus.parallel_out); else passes++;
    last_good = 8'h00;
    rx_bus.serial_in = 1'b1;
    tick_n(4);
    rst_n = 1'b1;
    tick_n(10);
    send_frame(8'h7E, 1'b1, 1'b0);
    tick_n(10);
    checks++;
    if (q.size() !== 0) $display("FAIL midrst_drain: got %0d pending, required 0", q.size()); else passes++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h01, 1'b1, 1'b1);
    tick_n(10);
    send_frame(8'h01, 1'b1, 1'b0);
    tick_n(10);
    checks += 2;
    if (q.size() !== 0) $display("FAIL parity_drain: got %0d pending, required 0", q.size()); else passes++;
    if (rx_bus.parallel_out !== 8'h01) $display("FAIL parity_word: got %h, required 01", rx_bus.parallel_out); else passes++;
  endtask
`endif

  initial begin
    rx_bus.serial_in = 1'b1;
    test_reset();
    test_single_frame();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
